// File: rtl/demorgan_pkg.sv
// Shared constants for the De Morgan datapath self-test sequencer.
package demorgan_pkg;

  localparam int NUM_VECS = 4;
  localparam int VEC_W    = 2;

  typedef logic [VEC_W-1:0] vec_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/demorgan_sweep_ctrl_if.sv
// Handshake, drive and result bundle between the sweep controller and its host/datapath.
interface demorgan_sweep_ctrl_if
  import demorgan_pkg::*;
#(
  parameter int ERR_W = 4
);
  logic                start;
  logic                drive_a;
  logic                drive_b;
  logic                nAandnB;
  logic                npAorB;
  logic                nAornB;
  logic                npAandB;
  logic                busy;
  logic                done;
  logic                pass;
  logic [ERR_W-1:0]    err_count;
  logic [NUM_VECS-1:0] fail_vec;

  modport master (
    output start, nAandnB, npAorB, nAornB, npAandB,
    input  drive_a, drive_b, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    input  start, nAandnB, npAorB, nAornB, npAandB,
    output drive_a, drive_b, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/demorgan_golden.sv
// Expected De Morgan outputs for a vector {A,B}, ordered {~A&~B, ~(A|B), ~A|~B, ~(A&B)}.
module demorgan_golden
  import demorgan_pkg::*;
(
  input  vec_t       vec_i,
  output logic [3:0] exp_o
);
  logic a;
  logic b;

  assign a     = vec_i[1];
  assign b     = vec_i[0];
  assign exp_o = {~a & ~b, ~(a | b), ~a | ~b, ~(a & b)};
endmodule

// File: rtl/demorgan_sweep_ctrl.sv
// Built-in self-test sequencer: sweeps all {A,B} vectors through the datapath and scores the results.
//   state  | meaning
//   IDLE   | waiting for start; results held
//   SETTLE | vector driven, counting down the settle time
//   SAMPLE | compare datapath outputs to golden, advance vector
//   DONE   | one-cycle done pulse, then back to IDLE
module demorgan_sweep_ctrl
  import demorgan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  demorgan_sweep_ctrl_if.slave  bus
);
  localparam int                CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
  localparam vec_t              VEC_LAST = vec_t'(NUM_VECS - 1);

  logic [1:0]          state_q, state_d;
  vec_t                vec_q, vec_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          drive_q, drive_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [NUM_VECS-1:0] fail_q, fail_d;

  logic [3:0]          exp_vec;
  logic                mismatch;

  demorgan_golden u_golden (
    .vec_i (vec_q),
    .exp_o (exp_vec)
  );

  assign mismatch = ({bus.nAandnB, bus.npAorB, bus.nAornB, bus.npAandB} != exp_vec);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    drive_d = drive_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SETTLE;
          vec_d   = '0;
          cnt_d   = CNT_LOAD;
          drive_d = 2'b00;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_SAMPLE: begin
        // Counter saturates; fail_vec keeps recording regardless.
        if (mismatch) begin
          fail_d[vec_q] = 1'b1;
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
        end
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
          vec_d   = '0;
          drive_d = 2'b00;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + 1'b1;
          drive_d = vec_q + 1'b1;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      drive_q <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      drive_q <= drive_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.drive_a   = drive_q[1];
  assign bus.drive_b   = drive_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;
endmodule
